// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// Op and FSM state types plus the iteration bound.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULU = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [4:0] ITER_LAST = 5'd31;

endpackage

// File: rtl/muldiv_seq_adder.sv
// 32-bit Kogge-Stone prefix adder with add/sub select.
// cout is carry-out for add and not-borrow for sub.
module adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        s_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] bx;
  logic [31:0] p0;
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign bx = b_i ^ {32{s_i}};
  assign p0 = a_i ^ bx;

  always_comb begin
    // carry-in folded into bit 0 generate
    g    = a_i & bx;
    g[0] = g[0] | (p0[0] & s_i);
    p    = p0;
    for (int k = 0; k < 5; k++) begin
      g = g | (p & (g << (1 << k)));
      p = p & (p << (1 << k));
    end
  end

  assign c      = {g, s_i};
  assign sum_o  = p0 ^ c[31:0];
  assign cout_o = c[32];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MULU/DIVU sequencer with single-pass ADD/SUB,
// all arithmetic time-shared on one prefix adder.
import muldiv_pkg::*;

module muldiv_seq #(
  parameter int WIDTH     = 32,
  parameter bit DIV0_FAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             abort,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_lo,
  output logic [WIDTH-1:0] resp_hi,
  output logic             resp_dz
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_s;
  logic [WIDTH-1:0] sum;
  logic             cout;

  logic [WIDTH-1:0] div_t;
  logic             take;
  logic             last;

  adder u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .s_i    (add_s),
    .sum_o  (sum),
    .cout_o (cout)
  );

  assign div_t = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign take  = hi_q[WIDTH-1] | cout;
  assign last  = (cnt_q == ITER_LAST);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    add_a   = '0;
    add_b   = '0;
    add_s   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_BUSY;
          op_d    = op_e'(req_op);
          cnt_d   = '0;
          a_d     = req_a;
          b_d     = req_b;
          hi_d    = '0;
          lo_d    = (op_e'(req_op) == OP_DIVU) ? req_a : req_b;
          dz_d    = (op_e'(req_op) == OP_DIVU) && (req_b == '0);
        end
      end
      ST_BUSY: begin
        unique case (op_q)
          OP_ADD, OP_SUB: begin
            add_a   = a_q;
            add_b   = b_q;
            add_s   = (op_q == OP_SUB);
            lo_d    = sum;
            hi_d    = {{(WIDTH-1){1'b0}}, cout};
            state_d = ST_DONE;
          end
          OP_MULU: begin
            add_a = hi_q;
            add_b = lo_q[0] ? a_q : '0;
            hi_d  = {cout, sum[WIDTH-1:1]};
            lo_d  = {sum[0], lo_q[WIDTH-1:1]};
            if (last) state_d = ST_DONE;
            else      cnt_d   = cnt_q + 5'd1;
          end
          OP_DIVU: begin
            if (DIV0_FAST && dz_q) begin
              // matches what the full restoring loop yields for D=0
              lo_d    = '1;
              hi_d    = a_q;
              state_d = ST_DONE;
            end else begin
              add_a = div_t;
              add_b = b_q;
              add_s = 1'b1;
              hi_d  = take ? sum : div_t;
              lo_d  = {lo_q[WIDTH-2:0], take};
              if (last) state_d = ST_DONE;
              else      cnt_d   = cnt_q + 5'd1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (abort || resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign resp_lo    = lo_q;
  assign resp_hi    = hi_q;
  assign resp_dz    = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq.
// Drives on negedge, samples on negedge.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        abort;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_lo;
  logic [31:0] resp_hi;
  logic        resp_dz;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32), .DIV0_FAST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .abort      (abort),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_lo    (resp_lo),
    .resp_hi    (resp_hi),
    .resp_dz    (resp_dz)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called at a negedge while IDLE; returns at the negedge after accept
  task automatic start(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] elo, input logic [31:0] ehi,
                       input logic edz, input int elat);
    int lat;
    resp_ready = 1'b1;
    start(op, a, b);
    wait_resp(lat);
    check({tag, " lat"}, 64'(lat), 64'(elat));
    check({tag, " lo"}, 64'(resp_lo), 64'(elo));
    check({tag, " hi"}, 64'(resp_hi), 64'(ehi));
    check({tag, " dz"}, 64'(resp_dz), 64'(edz));
    @(negedge clk);
    check({tag, " rv drop"}, 64'(resp_valid), 64'd0);
    check({tag, " rdy back"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] slo, shi;
    logic stable;
    logic seen;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = '0;
    req_b      = '0;
    abort      = 1'b0;
    resp_ready = 1'b0;
    #12;
    check("rst ready", 64'(req_ready), 64'd1);
    check("rst valid", 64'(resp_valid), 64'd0);
    check("rst lo", 64'(resp_lo), 64'd0);
    check("rst hi", 64'(resp_hi), 64'd0);
    check("rst dz", 64'(resp_dz), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("mul max", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'h00000001, 32'hFFFFFFFE, 1'b0, 33);
    do_op("mul x16", 2'b10, 32'h12345678, 32'h00000010,
          32'h23456780, 32'h00000001, 1'b0, 33);
    do_op("div 100/7", 2'b11, 32'd100, 32'd7,
          32'h0000000E, 32'h00000002, 1'b0, 33);
    do_op("div 8e/3", 2'b11, 32'h80000000, 32'd3,
          32'h2AAAAAAA, 32'h00000002, 1'b0, 33);
    do_op("div 7/100", 2'b11, 32'd7, 32'd100,
          32'h00000000, 32'h00000007, 1'b0, 33);
    do_op("div max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'h00000001, 32'h00000000, 1'b0, 33);
    do_op("div0", 2'b11, 32'd5, 32'd0,
          32'hFFFFFFFF, 32'h00000005, 1'b1, 2);
    do_op("sub 3-5", 2'b01, 32'd3, 32'd5,
          32'hFFFFFFFE, 32'h00000000, 1'b0, 2);
    do_op("sub 5-3", 2'b01, 32'd5, 32'd3,
          32'h00000002, 32'h00000001, 1'b0, 2);
    do_op("add wrap", 2'b00, 32'hFFFFFFFF, 32'd1,
          32'h00000000, 32'h00000001, 1'b0, 2);

    // consumer stall in DONE
    resp_ready = 1'b0;
    start(2'b10, 32'd6, 32'd7);
    wait_resp(lat);
    check("stall lat", 64'(lat), 64'd33);
    slo    = resp_lo;
    shi    = resp_hi;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!resp_valid || req_ready || resp_lo != slo || resp_hi != shi)
        stable = 1'b0;
    end
    check("stall stable", 64'(stable), 64'd1);
    check("stall lo", 64'(slo), 64'd42);
    resp_ready = 1'b1;
    @(negedge clk);
    check("stall release", 64'(resp_valid), 64'd0);

    // back-to-back with resp_ready held high
    for (int i = 0; i < 4; i++)
      do_op("b2b add", 2'b00, 32'(i * 3), 32'd10,
            32'(i * 3 + 10), 32'd0, 1'b0, 2);

    // abort at BUSY cycle 10 of MULU
    start(2'b10, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort ready", 64'(req_ready), 64'd1);
    check("abort valid", 64'(resp_valid), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("abort no resp", 64'(seen), 64'd0);
    do_op("post abort", 2'b10, 32'd1000, 32'd1000,
          32'd1000000, 32'd0, 1'b0, 33);

    // abort in IDLE is ignored and a same-cycle request is taken
    abort = 1'b1;
    start(2'b00, 32'd2, 32'd2);
    abort = 1'b0;
    wait_resp(lat);
    check("idle abort lat", 64'(lat), 64'd2);
    check("idle abort lo", 64'(resp_lo), 64'd4);
    @(negedge clk);

    // reset pulse mid-DIVU
    start(2'b11, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst mid ready", 64'(req_ready), 64'd1);
    check("rst mid lo", 64'(resp_lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("rst no resp", 64'(seen), 64'd0);
    do_op("post rst", 2'b11, 32'd1000, 32'd33,
          32'd30, 32'd10, 1'b0, 33);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
